// File: rtl/axi_mca_regs_if.sv
// AXI4-Lite channel bundle for the MCA register bank.
// The slave modport is the register bank's view; the master modport is the interconnect's.
interface axi_mca_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Write address channel
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    // Write data channel
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    // Write response channel
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    // Read address channel
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    // Read data channel
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_mca_regs.sv
// AXI4-Lite register bank for the MCA datapath: R/W control registers (index 0 is a
// self-clearing command register), read-only status registers and decoupled AW/W/AR acceptance.
module axi_mca_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_CTRL           = 8,
    parameter int NUM_STAT           = 8
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    axi_mca_regs_if.slave                          s00_axi,
    output logic [C_S_AXI_DATA_WIDTH*NUM_CTRL-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]                    ctrl_wr_stb,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          cmd_pulse,
    input  logic [C_S_AXI_DATA_WIDTH*NUM_STAT-1:0] stat_in
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = AW - 2;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [IW:0] CTRL_END    = (IW+1)'(NUM_CTRL);
    localparam logic [IW:0] STAT_END    = (IW+1)'(NUM_CTRL + NUM_STAT);

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e                     w_state_q, w_state_d;
    logic                         awready_q, awready_d;
    logic                         wready_q, wready_d;
    logic                         aw_held_q, aw_held_d;
    logic                         w_held_q, w_held_d;
    logic [AW-1:0]                awaddr_q, awaddr_d;
    logic [DW-1:0]                wdata_q, wdata_d;
    logic [SW-1:0]                wstrb_q, wstrb_d;
    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic [NUM_CTRL-1:0][DW-1:0]  ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]          ctrl_wr_stb_q, ctrl_wr_stb_d;
    logic [DW-1:0]                cmd_pulse_q, cmd_pulse_d;

    logic                         aw_hs;
    logic                         w_hs;
    logic [IW-1:0]                widx;
    logic [DW-1:0]                strb_mask;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e                     r_state_q, r_state_d;
    logic                         arready_q, arready_d;
    logic                         rvalid_q, rvalid_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic [DW-1:0]                rdata_q, rdata_d;

    logic                         ar_hs;
    logic [IW-1:0]                ridx;

    assign aw_hs = s00_axi.awvalid & awready_q;
    assign w_hs  = s00_axi.wvalid & wready_q;
    assign ar_hs = s00_axi.arvalid & arready_q;

    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_d     = w_state_q;
        awready_d     = awready_q;
        wready_d      = wready_q;
        aw_held_d     = aw_held_q;
        w_held_d      = w_held_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        ctrl_d        = ctrl_q;
        ctrl_wr_stb_d = '0;
        cmd_pulse_d   = '0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s00_axi.awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s00_axi.wdata;
            wstrb_d  = s00_axi.wstrb;
        end

        // Commit uses the post-handshake view so the write lands on the edge of the last handshake.
        widx      = awaddr_d[AW-1:2];
        strb_mask = '0;
        for (int b = 0; b < SW; b++) begin
            strb_mask[8*b +: 8] = {8{wstrb_d[b]}};
        end

        case (w_state_q)
            W_IDLE: begin
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    if ({1'b0, widx} < CTRL_END) begin
                        bresp_d = RESP_OKAY;
                        for (int i = 0; i < NUM_CTRL; i++) begin
                            if (widx == IW'(i)) ctrl_wr_stb_d[i] = 1'b1;
                        end
                        for (int i = 1; i < NUM_CTRL; i++) begin
                            if (widx == IW'(i)) begin
                                ctrl_d[i] = (ctrl_q[i] & ~strb_mask) | (wdata_d & strb_mask);
                            end
                        end
                        if (widx == '0) cmd_pulse_d = wdata_d & strb_mask;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: the control bank is plain flops, not RAM, so it is cleared by reset like any other state.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            // NOTE: sequential state is updated with <= so every flop sees pre-edge values of the others.
            w_state_q     <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            ctrl_q        <= '0;
            ctrl_wr_stb_q <= '0;
            cmd_pulse_q   <= '0;
        end else begin
            w_state_q     <= w_state_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            ctrl_q        <= ctrl_d;
            ctrl_wr_stb_q <= ctrl_wr_stb_d;
            cmd_pulse_q   <= cmd_pulse_d;
        end
    end

    // Read data comes from ctrl_q, so a same-edge write is not yet visible to the read.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ridx      = s00_axi.araddr[AW-1:2];

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    if ({1'b0, ridx} < CTRL_END) begin
                        for (int i = 1; i < NUM_CTRL; i++) begin
                            if (ridx == IW'(i)) rdata_d = ctrl_q[i];
                        end
                    end else if ({1'b0, ridx} < STAT_END) begin
                        for (int j = 0; j < NUM_STAT; j++) begin
                            if ({1'b0, ridx} == (IW+1)'(NUM_CTRL + j)) rdata_d = stat_in[DW*j +: DW];
                        end
                    end else begin
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = wready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    assign ctrl_out    = ctrl_q;
    assign ctrl_wr_stb = ctrl_wr_stb_q;
    assign cmd_pulse   = cmd_pulse_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_axi_mca_regs.sv
// Directed self-checking bench for axi_mca_regs (default 8 control + 8 status registers).
module tb_axi_mca_regs;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    axi_mca_regs_if #(.ADDR_W(AW), .DATA_W(DW)) s_axi ();

    logic [DW*NC-1:0] ctrl_out;
    logic [NC-1:0]    ctrl_wr_stb;
    logic [DW-1:0]    cmd_pulse;
    logic [DW*NS-1:0] stat_in;

    axi_mca_regs #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_CTRL(NC),
        .NUM_STAT(NS)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi         (s_axi),
        .ctrl_out        (ctrl_out),
        .ctrl_wr_stb     (ctrl_wr_stb),
        .cmd_pulse       (cmd_pulse),
        .stat_in         (stat_in)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_ctrl [NC];
    int          stb_cnt  [NC];
    int          cmd_cycles;
    logic [31:0] cmd_last;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: sees pre-edge values, so each one-cycle pulse is counted once.
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) if (ctrl_wr_stb[i] === 1'b1) stb_cnt[i]++;
        if (cmd_pulse !== '0) begin
            cmd_cycles++;
            cmd_last = cmd_pulse;
        end
    end

    function automatic logic [DW*NC-1:0] exp_vec();
        logic [DW*NC-1:0] v;
        for (int i = 0; i < NC; i++) v[32*i +: 32] = exp_ctrl[i];
        return v;
    endfunction

    task automatic check_ctrl(input string tag);
        check(tag, ctrl_out, exp_vec());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_w(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_done, w_done, aw_fire, w_fire;
        int   cyc;
        s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
        s_axi.wdata  = data; s_axi.wstrb   = strb; s_axi.wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_fire = s_axi.awvalid && s_axi.awready;
            w_fire  = s_axi.wvalid && s_axi.wready;
            tick();
            cyc++;
            if (aw_fire) begin aw_done = 1'b1; s_axi.awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; s_axi.wvalid  = 1'b0; end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int cyc = 0;
        while (s_axi.bvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        if (s_axi.bvalid !== 1'b1) check("bvalid_timeout", s_axi.bvalid, 1'b1);
        resp = s_axi.bresp;
        tick();
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        aw_w(addr, data, strb);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic fire, done;
        int   cyc;
        s_axi.araddr = addr; s_axi.arvalid = 1'b1;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 20) begin
            fire = s_axi.arvalid && s_axi.arready;
            tick();
            cyc++;
            if (fire) done = 1'b1;
        end
        s_axi.arvalid = 1'b0;
        if (!done) check("ar_handshake_timeout", done, 1'b1);
        cyc = 0;
        while (s_axi.rvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        if (s_axi.rvalid !== 1'b1) check("rvalid_timeout", s_axi.rvalid, 1'b1);
        data = s_axi.rdata;
        resp = s_axi.rresp;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_readies"}, {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        check({tag, "_valids"},  {s_axi.bvalid, s_axi.rvalid}, 2'b00);
        check({tag, "_resps"},   {s_axi.bresp, s_axi.rresp}, 4'h0);
        check({tag, "_rdata"},   s_axi.rdata, 32'h0);
        check({tag, "_ctrl"},    ctrl_out, '0);
        check({tag, "_stb"},     ctrl_wr_stb, '0);
        check({tag, "_cmd"},     cmd_pulse, 32'h0);
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;
    int          stb_total;

    initial begin
        aresetn = 1'b0;
        s_axi.awaddr = '0; s_axi.awprot = 3'b010; s_axi.awvalid = 1'b0;
        s_axi.wdata  = '0; s_axi.wstrb  = '0;     s_axi.wvalid  = 1'b0;
        s_axi.bready = 1'b1;
        s_axi.araddr = '0; s_axi.arprot = 3'b101; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b1;
        stat_in = '0;
        for (int i = 0; i < NC; i++) begin exp_ctrl[i] = '0; stb_cnt[i] = 0; end
        cmd_cycles = 0;
        cmd_last   = '0;

        // Reset state
        repeat (3) tick();
        check_all_zero("rst");
        aresetn = 1'b1;
        tick();
        check("readies_after_rst", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);

        // Basic write/readback of registers 1..4
        for (int i = 1; i <= 4; i++) begin
            axi_write(8'(4*i), 32'(i), 4'hF, rsp);
            exp_ctrl[i] = 32'(i);
            check($sformatf("wr%0d_bresp", i), rsp, 2'b00);
        end
        for (int i = 1; i <= 4; i++) begin
            axi_read(8'(4*i), rd, rsp);
            check($sformatf("rd%0d_data", i), rd, 32'(i));
            check($sformatf("rd%0d_rresp", i), rsp, 2'b00);
        end
        for (int i = 0; i < NC; i++) begin
            check($sformatf("stb_cnt%0d", i), stb_cnt[i], (i >= 1 && i <= 4) ? 1 : 0);
        end
        check_ctrl("ctrl_after_basic");

        // Same-edge read and write of index 3: read returns the old value
        s_axi.awaddr = 8'h0C; s_axi.wdata = 32'h77; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        s_axi.araddr = 8'h0C; s_axi.arvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        exp_ctrl[3] = 32'h77;
        check("simul_valids", {s_axi.rvalid, s_axi.bvalid}, 2'b11);
        check("simul_rdata_old", s_axi.rdata, 32'h3);
        check_ctrl("simul_ctrl_new");
        tick();
        check("simul_done", {s_axi.rvalid, s_axi.bvalid}, 2'b00);

        // W three cycles ahead of AW, partial strobes
        axi_write(8'h08, 32'h11223344, 4'hF, rsp);
        exp_ctrl[2] = 32'h11223344;
        s_axi.wdata = 32'hAABBCCDD; s_axi.wstrb = 4'b0101; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        check("early_w_latched", s_axi.wready, 1'b0);
        repeat (2) tick();
        check("early_w_no_bvalid", s_axi.bvalid, 1'b0);
        check("early_w_awready", s_axi.awready, 1'b1);
        s_axi.awaddr = 8'h08; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        exp_ctrl[2] = 32'h11BB33DD;
        check("early_w_bvalid", s_axi.bvalid, 1'b1);
        check("early_w_bresp", s_axi.bresp, 2'b00);
        check_ctrl("early_w_merge");
        tick();
        check("early_w_b_done", s_axi.bvalid, 1'b0);

        // Command register
        axi_write(8'h00, 32'h80000005, 4'hF, rsp);
        check("cmd_bresp", rsp, 2'b00);
        check("cmd_cycles", cmd_cycles, 1);
        check("cmd_value", cmd_last, 32'h80000005);
        check("cmd_stb0", stb_cnt[0], 1);
        axi_write(8'h00, 32'hFFFFFFFF, 4'b0011, rsp);
        check("cmd_masked_cycles", cmd_cycles, 2);
        check("cmd_masked_value", cmd_last, 32'h0000FFFF);
        axi_read(8'h00, rd, rsp);
        check("cmd_read_zero", rd, 32'h0);
        check("cmd_read_rresp", rsp, 2'b00);
        check_ctrl("ctrl_after_cmd");

        // wstrb=0 to a valid index: strobe fires, nothing changes
        axi_write(8'h18, 32'hFFFFFFFF, 4'h0, rsp);
        check("nostrb_bresp", rsp, 2'b00);
        check("nostrb_stb6", stb_cnt[6], 1);
        check_ctrl("nostrb_ctrl");

        // Last control index
        axi_write(8'h1C, 32'h0F0F0F0F, 4'hF, rsp);
        exp_ctrl[7] = 32'h0F0F0F0F;
        axi_read(8'h1C, rd, rsp);
        check("last_ctrl_data", rd, 32'h0F0F0F0F);
        check("last_ctrl_rresp", rsp, 2'b00);

        // Status registers and illegal accesses
        stat_in[31:0]        = 32'hDEADBEEF;
        stat_in[32*7 +: 32]  = 32'h0BADF00D;
        axi_read(8'(4*NC), rd, rsp);
        check("stat0_data", rd, 32'hDEADBEEF);
        check("stat0_rresp", rsp, 2'b00);
        axi_read(8'(4*(NC+NS-1)), rd, rsp);
        check("stat7_data", rd, 32'h0BADF00D);
        stb_total = 0;
        for (int i = 0; i < NC; i++) stb_total += stb_cnt[i];
        axi_write(8'(4*NC), 32'h12345678, 4'hF, rsp);
        check("stat_wr_bresp", rsp, 2'b10);
        axi_write(8'hFC, 32'h12345678, 4'hF, rsp);
        check("oor_wr_bresp", rsp, 2'b10);
        for (int i = 0; i < NC; i++) stb_total -= stb_cnt[i];
        check("illegal_wr_no_stb", stb_total, 0);
        check_ctrl("illegal_wr_ctrl");
        axi_read(8'(4*NC), rd, rsp);
        check("stat0_unchanged", rd, 32'hDEADBEEF);
        axi_read(8'(4*(NC+NS)), rd, rsp);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_rresp", rsp, 2'b10);

        // B-channel backpressure
        s_axi.bready = 1'b0;
        aw_w(8'h10, 32'h5A5A5A5A, 4'hF);
        exp_ctrl[4] = 32'h5A5A5A5A;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_bvalid_%0d", k), {s_axi.bvalid, s_axi.bresp}, 3'b100);
            check($sformatf("bp_readies_%0d", k), {s_axi.awready, s_axi.wready}, 2'b00);
            tick();
        end
        s_axi.bready = 1'b1;
        tick();
        check("bp_done_bvalid", s_axi.bvalid, 1'b0);
        check("bp_done_awready", s_axi.awready, 1'b1);
        check_ctrl("bp_ctrl");

        // Reset after AW but before W
        s_axi.awaddr = 8'h14; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        check("mid_aw_latched", s_axi.awready, 1'b0);
        aresetn = 1'b0;
        tick();
        for (int i = 0; i < NC; i++) exp_ctrl[i] = '0;
        check_all_zero("mid_rst");
        aresetn = 1'b1;
        repeat (3) tick();
        check("mid_no_bvalid", s_axi.bvalid, 1'b0);
        check("mid_no_stb5", stb_cnt[5], 0);
        check_ctrl("mid_ctrl");
        axi_write(8'h14, 32'hCAFEF00D, 4'hF, rsp);
        exp_ctrl[5] = 32'hCAFEF00D;
        check("post_rst_bresp", rsp, 2'b00);
        axi_read(8'h14, rd, rsp);
        check("post_rst_rdata", rd, 32'hCAFEF00D);
        check_ctrl("post_rst_ctrl");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
